exc_prio_arbiter: RTL and testbench

//  Parametrised exception priority arbiter and redirect sequencer for the MIPS core's memory stage.

---
 rtl/exc_prio_arbiter_if.sv | 62 ++++++
 rtl/exc_prio_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_exc_prio_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_prio_arbiter_if.sv
// rtl/exc_prio_arbiter_if.sv - cause, CP0-update and fetch-redirect bundle for exc_prio_arbiter
//
// Purpose: groups everything between the memory stage, CP0 and the fetch unit
//          and the exception arbiter. The slave modport is the arbiter's side.
//          The master modport is the side of the core that drives causes and the
//          fetch handshake.
// Signals (arbiter's view):
//   in : src_req, src_code, src_refill, src_badv, src_vaddr, exc_epc,
//        int_pending, int_enable, eret, epc_in, bev, exl, iv,
//        fetch_ready, fetch_done
//   out: flush, exc_now, wr_exp, clear_exl, exp_code, epc, badvaddr_we,
//        badvaddr, new_pc, new_pc_valid
interface exc_prio_arbiter_if #(
  parameter int NUM_SRC   = 12,
  parameter int NUM_FLUSH = 4
);
  // cause requesters
  logic [NUM_SRC-1:0]    src_req;
  logic [5*NUM_SRC-1:0]  src_code;
  logic [NUM_SRC-1:0]    src_refill;
  logic [NUM_SRC-1:0]    src_badv;
  logic [32*NUM_SRC-1:0] src_vaddr;
  logic [31:0]           exc_epc;
  // interrupts, ERET and CP0 status
  logic [7:0]            int_pending;
  logic                  int_enable;
  logic                  eret;
  logic [31:0]           epc_in;
  logic                  bev;
  logic                  exl;
  logic                  iv;
  // fetch handshake
  logic                  fetch_ready;
  logic                  fetch_done;
  // arbiter outputs
  logic [NUM_FLUSH-1:0]  flush;
  logic                  exc_now;
  logic                  wr_exp;
  logic                  clear_exl;
  logic [4:0]            exp_code;
  logic [31:0]           epc;
  logic                  badvaddr_we;
  logic [31:0]           badvaddr;
  logic [31:0]           new_pc;
  logic                  new_pc_valid;

  modport master (
    output src_req, src_code, src_refill, src_badv, src_vaddr, exc_epc,
    output int_pending, int_enable, eret, epc_in, bev, exl, iv,
    output fetch_ready, fetch_done,
    input  flush, exc_now, wr_exp, clear_exl, exp_code, epc,
    input  badvaddr_we, badvaddr, new_pc, new_pc_valid
  );

  modport slave (
    input  src_req, src_code, src_refill, src_badv, src_vaddr, exc_epc,
    input  int_pending, int_enable, eret, epc_in, bev, exl, iv,
    input  fetch_ready, fetch_done,
    output flush, exc_now, wr_exp, clear_exl, exp_code, epc,
    output badvaddr_we, badvaddr, new_pc, new_pc_valid
  );
endinterface

// File: rtl/exc_prio_arbiter.sv
// rtl/exc_prio_arbiter.sv - exception priority arbiter and redirect sequencer
//
// Purpose: in IDLE, picks interrupt > src_req[0] > ... > src_req[NUM_SRC-1] > eret.
//          The cycle after a winner is found, it pulses the CP0 update
//          (wr_exp or clear_exl, plus badvaddr_we). It also raises flush and
//          presents new_pc/new_pc_valid to fetch. flush is held until fetch has
//          taken the redirect and returned its first fetch.
// Ports:
//   clk     in   core clock
//   resetn  in   synchronous reset, active low
//   bus     slave modport of exc_prio_arbiter_if (causes, CP0 values, fetch
//           handshake in; flush, CP0 update, redirect out)
module exc_prio_arbiter #(
  parameter int          NUM_SRC   = 12,
  parameter int          NUM_FLUSH = 4,
  parameter logic [31:0] BOOT_BASE = 32'hBFC0_0200,
  parameter logic [31:0] NORM_BASE = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                resetn,
  exc_prio_arbiter_if.slave   bus
);

  localparam logic [31:0] OFF_REFILL = 32'h0000_0000;
  localparam logic [31:0] OFF_GENERAL = 32'h0000_0180;
  localparam logic [31:0] OFF_INT_IV = 32'h0000_0200;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_FLUSH-1:0]  flush_q, flush_d;
  logic                  wr_exp_q, wr_exp_d;
  logic                  clear_exl_q, clear_exl_d;
  logic [4:0]            exp_code_q, exp_code_d;
  logic [31:0]           epc_q, epc_d;
  logic                  badvaddr_we_q, badvaddr_we_d;
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           new_pc_q, new_pc_d;
  logic                  new_pc_valid_q, new_pc_valid_d;

  // Winner selection among synchronous sources
  logic                  irq;
  logic                  sel_found;
  logic [4:0]            sel_code;
  logic [31:0]           sel_vaddr;
  logic                  sel_badv;
  logic                  sel_refill;
  logic [31:0]           vec_base;

  assign irq      = bus.int_enable & (|bus.int_pending);
  assign vec_base = bus.bev ? BOOT_BASE : NORM_BASE;

  // Scan from lowest priority upward so the last hit, the lowest index, wins.
  always_comb begin
    sel_found  = 1'b0;
    sel_code   = 5'd0;
    sel_vaddr  = 32'd0;
    sel_badv   = 1'b0;
    sel_refill = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_req[i]) begin
        sel_found  = 1'b1;
        sel_code   = bus.src_code[5*i +: 5];
        sel_vaddr  = bus.src_vaddr[32*i +: 32];
        sel_badv   = bus.src_badv[i];
        sel_refill = bus.src_refill[i];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    flush_d        = flush_q;
    wr_exp_d       = 1'b0;
    clear_exl_d    = 1'b0;
    badvaddr_we_d  = 1'b0;
    badvaddr_d     = 32'd0;
    exp_code_d     = exp_code_q;
    epc_d          = epc_q;
    new_pc_d       = new_pc_q;
    new_pc_valid_d = new_pc_valid_q;

    case (state_q)
      S_IDLE: begin
        if (irq) begin
          wr_exp_d   = 1'b1;
          exp_code_d = 5'd0;
          epc_d      = bus.exc_epc;
          new_pc_d   = vec_base + (bus.iv ? OFF_INT_IV : OFF_GENERAL);
        end else if (sel_found) begin
          wr_exp_d      = 1'b1;
          exp_code_d    = sel_code;
          epc_d         = bus.exc_epc;
          badvaddr_we_d = sel_badv;
          badvaddr_d    = sel_badv ? sel_vaddr : 32'd0;
          // A refill taken while already at EXL goes to the general vector.
          new_pc_d      = vec_base + ((sel_refill & ~bus.exl) ? OFF_REFILL : OFF_GENERAL);
        end else if (bus.eret) begin
          // ERET only clears EXL; EPC and ExcCode keep their last values.
          clear_exl_d = 1'b1;
          new_pc_d    = bus.epc_in;
        end

        if (irq | sel_found | bus.eret) begin
          flush_d        = {NUM_FLUSH{1'b1}};
          new_pc_valid_d = 1'b1;
          state_d        = S_REDIR;
        end
      end

      S_REDIR: begin
        if (bus.fetch_ready) begin
          new_pc_valid_d = 1'b0;
          // A first fetch that returns on the handshake cycle skips DRAIN.
          if (bus.fetch_done) begin
            flush_d = {NUM_FLUSH{1'b0}};
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (bus.fetch_done) begin
          flush_d = {NUM_FLUSH{1'b0}};
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d        = S_IDLE;
        flush_d        = {NUM_FLUSH{1'b0}};
        new_pc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      flush_q        <= {NUM_FLUSH{1'b0}};
      wr_exp_q       <= 1'b0;
      clear_exl_q    <= 1'b0;
      exp_code_q     <= 5'd0;
      epc_q          <= 32'd0;
      badvaddr_we_q  <= 1'b0;
      badvaddr_q     <= 32'd0;
      new_pc_q       <= 32'd0;
      new_pc_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      wr_exp_q       <= wr_exp_d;
      clear_exl_q    <= clear_exl_d;
      exp_code_q     <= exp_code_d;
      epc_q          <= epc_d;
      badvaddr_we_q  <= badvaddr_we_d;
      badvaddr_q     <= badvaddr_d;
      new_pc_q       <= new_pc_d;
      new_pc_valid_q <= new_pc_valid_d;
    end
  end

  // exc_now is combinational so the memory stage can squash in the same cycle.
  assign bus.exc_now      = (state_q == S_IDLE) & (irq | (|bus.src_req) | bus.eret);
  assign bus.flush        = flush_q;
  assign bus.wr_exp       = wr_exp_q;
  assign bus.clear_exl    = clear_exl_q;
  assign bus.exp_code     = exp_code_q;
  assign bus.epc          = epc_q;
  assign bus.badvaddr_we  = badvaddr_we_q;
  assign bus.badvaddr     = badvaddr_q;
  assign bus.new_pc       = new_pc_q;
  assign bus.new_pc_valid = new_pc_valid_q;

endmodule

// File: tb/tb_exc_prio_arbiter.sv
// tb/tb_exc_prio_arbiter.sv - self-checking bench for exc_prio_arbiter
module tb_exc_prio_arbiter;
  localparam int NS = 12;
  localparam int NF = 4;
  localparam logic [31:0] BOOTB = 32'hBFC0_0200;
  localparam logic [31:0] NORMB = 32'h8000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_prio_arbiter_if #(.NUM_SRC(NS), .NUM_FLUSH(NF)) bus();

  exc_prio_arbiter #(
    .NUM_SRC(NS), .NUM_FLUSH(NF), .BOOT_BASE(BOOTB), .NORM_BASE(NORMB)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] req;
    logic [11:0] refill;
    logic [11:0] badv;
    logic        int_en;
    logic [7:0]  pend;
    logic        eret;
    logic        bev;
    logic        exl;
    logic        iv;
    logic [31:0] epc_in;
    logic        e_take;
    logic        e_wr;
    logic        e_clr;
    logic [4:0]  e_code;
    logic        e_bwe;
    logic [31:0] e_badv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_srcs();
    for (int i = 0; i < NS; i++) begin
      bus.src_code[5*i +: 5]   = 5'(i + 1);
      bus.src_vaddr[32*i +: 32] = 32'h1000 + 32'(i);
    end
  endtask

  task automatic clear_inputs();
    bus.src_req     = '0;
    bus.src_refill  = '0;
    bus.src_badv    = '0;
    bus.int_pending = '0;
    bus.int_enable  = 1'b0;
    bus.eret        = 1'b0;
    bus.bev         = 1'b0;
    bus.exl         = 1'b0;
    bus.iv          = 1'b0;
    bus.epc_in      = '0;
    bus.exc_epc     = '0;
    bus.fetch_ready = 1'b0;
    bus.fetch_done  = 1'b0;
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, " flush"},        32'(bus.flush), 32'h0);
    chk({p, " wr_exp"},       32'(bus.wr_exp), 32'h0);
    chk({p, " clear_exl"},    32'(bus.clear_exl), 32'h0);
    chk({p, " exp_code"},     32'(bus.exp_code), 32'h0);
    chk({p, " epc"},          bus.epc, 32'h0);
    chk({p, " badvaddr_we"},  32'(bus.badvaddr_we), 32'h0);
    chk({p, " badvaddr"},     bus.badvaddr, 32'h0);
    chk({p, " new_pc"},       bus.new_pc, 32'h0);
    chk({p, " new_pc_valid"}, 32'(bus.new_pc_valid), 32'h0);
  endtask

  // Reference: list every active cause in priority order and take the head.
  // kind: 0 none, 1 interrupt, 2 source idx, 3 eret
  function automatic void ref_winner(input logic [11:0] req, input logic int_en,
                                     input logic [7:0] pend, input logic eret,
                                     output int kind, output int idx);
    int q[$];
    if (int_en && pend != 8'h00) q.push_back(-1);
    for (int i = 0; i < NS; i++) if (req[i]) q.push_back(i);
    if (eret) q.push_back(100);
    kind = 0;
    idx  = 0;
    if (q.size() > 0) begin
      if (q[0] == -1)       kind = 1;
      else if (q[0] == 100) kind = 3;
      else begin kind = 2; idx = q[0]; end
    end
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_epc;
    logic [31:0] m_epc;
    logic [4:0]  m_code;
    int          kind, idx;
    logic [31:0] base, e_pc, e_badv, e_epc, held_pc;
    logic [4:0]  e_code;
    logic        e_bwe;
    logic        done_now;
    int          nstall;

    //                req     refill  badv    ie    pend   eret  bev   exl   iv    epc_in         take  wr    clr   code   bwe   badv          pc
    vt[0]  = '{12'h008, 12'h000, 12'h008, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'h04, 1'b1, 32'h0000_1003, 32'hBFC0_0380};
    vt[1]  = '{12'h084, 12'h004, 12'h080, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'h03, 1'b0, 32'h0,         32'h8000_0000};
    vt[2]  = '{12'h084, 12'h004, 12'h080, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'h03, 1'b0, 32'h0,         32'h8000_0180};
    vt[3]  = '{12'h001, 12'h000, 12'h001, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0,         32'h8000_0200};
    vt[4]  = '{12'h000, 12'h000, 12'h000, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0,         32'hBFC0_0380};
    vt[5]  = '{12'h000, 12'h000, 12'h000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_1234, 1'b1, 1'b0, 1'b1, 5'h00, 1'b0, 32'h0,       32'h8000_1234};
    vt[6]  = '{12'h800, 12'h000, 12'h800, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'h0C, 1'b1, 32'h0000_100B, 32'h8000_0180};
    vt[7]  = '{12'h001, 12'h001, 12'h000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'h01, 1'b0, 32'h0,         32'hBFC0_0200};
    vt[8]  = '{12'h020, 12'h000, 12'h000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 5'h06, 1'b0, 32'h0,       32'h8000_0180};
    vt[9]  = '{12'h000, 12'h000, 12'h000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 5'h06, 1'b0, 32'h0,         32'h8000_0180};
    vt[10] = '{12'h000, 12'h000, 12'h000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 5'h06, 1'b0, 32'h0,       32'hFFFF_FFFC};

    clear_inputs();
    set_default_srcs();

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    resetn = 1'b1;
    tick();
    chk_all_zero("post_reset");
    chk("post_reset exc_now", 32'(bus.exc_now), 32'h0);

    // Table-driven vectors, each closed with a same-cycle ready+done handshake
    exp_epc = 32'h0;
    for (int k = 0; k < 11; k++) begin
      bus.src_req     = vt[k].req;
      bus.src_refill  = vt[k].refill;
      bus.src_badv    = vt[k].badv;
      bus.int_enable  = vt[k].int_en;
      bus.int_pending = vt[k].pend;
      bus.eret        = vt[k].eret;
      bus.bev         = vt[k].bev;
      bus.exl         = vt[k].exl;
      bus.iv          = vt[k].iv;
      bus.epc_in      = vt[k].epc_in;
      bus.exc_epc     = 32'h0040_0000 + 32'(k * 4);
      if (vt[k].e_wr) exp_epc = bus.exc_epc;
      #1;
      chk($sformatf("v%0d exc_now", k), 32'(bus.exc_now), 32'(vt[k].e_take));
      tick();
      if (vt[k].e_take) begin
        chk($sformatf("v%0d wr_exp", k),       32'(bus.wr_exp), 32'(vt[k].e_wr));
        chk($sformatf("v%0d clear_exl", k),    32'(bus.clear_exl), 32'(vt[k].e_clr));
        chk($sformatf("v%0d exp_code", k),     32'(bus.exp_code), 32'(vt[k].e_code));
        chk($sformatf("v%0d epc", k),          bus.epc, exp_epc);
        chk($sformatf("v%0d badvaddr_we", k),  32'(bus.badvaddr_we), 32'(vt[k].e_bwe));
        chk($sformatf("v%0d badvaddr", k),     bus.badvaddr, vt[k].e_badv);
        chk($sformatf("v%0d new_pc", k),       bus.new_pc, vt[k].e_pc);
        chk($sformatf("v%0d new_pc_valid", k), 32'(bus.new_pc_valid), 32'h1);
        chk($sformatf("v%0d flush", k),        32'(bus.flush), 32'hF);
        clear_inputs();
        tick();
        chk($sformatf("v%0d wr_exp_pulse", k),   32'(bus.wr_exp), 32'h0);
        chk($sformatf("v%0d clear_exl_pulse", k), 32'(bus.clear_exl), 32'h0);
        chk($sformatf("v%0d badvaddr_clr", k),   bus.badvaddr, 32'h0);
        chk($sformatf("v%0d new_pc_hold", k),    bus.new_pc, vt[k].e_pc);
        chk($sformatf("v%0d valid_hold", k),     32'(bus.new_pc_valid), 32'h1);
        bus.fetch_ready = 1'b1;
        bus.fetch_done  = 1'b1;
        tick();
        bus.fetch_ready = 1'b0;
        bus.fetch_done  = 1'b0;
        chk($sformatf("v%0d flush_drop", k), 32'(bus.flush), 32'h0);
        chk($sformatf("v%0d valid_drop", k), 32'(bus.new_pc_valid), 32'h0);
      end else begin
        chk($sformatf("v%0d idle_wr_exp", k), 32'(bus.wr_exp), 32'h0);
        chk($sformatf("v%0d idle_valid", k),  32'(bus.new_pc_valid), 32'h0);
        chk($sformatf("v%0d idle_flush", k),  32'(bus.flush), 32'h0);
        clear_inputs();
      end
    end

    // ERET held in REDIR, requests ignored outside IDLE, then taken after drain
    bus.eret   = 1'b1;
    bus.epc_in = 32'h8000_1234;
    #1;
    chk("seqA exc_now", 32'(bus.exc_now), 32'h1);
    tick();
    chk("seqA clear_exl", 32'(bus.clear_exl), 32'h1);
    chk("seqA wr_exp", 32'(bus.wr_exp), 32'h0);
    chk("seqA new_pc", bus.new_pc, 32'h8000_1234);
    bus.eret    = 1'b0;
    bus.src_req = 12'h010;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("seqA stall%0d exc_now", j), 32'(bus.exc_now), 32'h0);
      tick();
      chk($sformatf("seqA stall%0d valid", j),  32'(bus.new_pc_valid), 32'h1);
      chk($sformatf("seqA stall%0d flush", j),  32'(bus.flush), 32'hF);
      chk($sformatf("seqA stall%0d new_pc", j), bus.new_pc, 32'h8000_1234);
      chk($sformatf("seqA stall%0d wr_exp", j), 32'(bus.wr_exp), 32'h0);
    end
    bus.fetch_ready = 1'b1;
    tick();
    bus.fetch_ready = 1'b0;
    chk("seqA drain valid", 32'(bus.new_pc_valid), 32'h0);
    chk("seqA drain flush", 32'(bus.flush), 32'hF);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("seqA drain%0d exc_now", j), 32'(bus.exc_now), 32'h0);
      tick();
      chk($sformatf("seqA drain%0d wr_exp", j), 32'(bus.wr_exp), 32'h0);
      chk($sformatf("seqA drain%0d flush", j),  32'(bus.flush), 32'hF);
    end
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
    chk("seqA flush_drop", 32'(bus.flush), 32'h0);
    chk("seqA wr_exp_none", 32'(bus.wr_exp), 32'h0);
    #1;
    chk("seqA idle exc_now", 32'(bus.exc_now), 32'h1);
    tick();
    chk("seqA taken wr_exp", 32'(bus.wr_exp), 32'h1);
    chk("seqA taken code", 32'(bus.exp_code), 32'h05);
    clear_inputs();
    bus.fetch_ready = 1'b1;
    bus.fetch_done  = 1'b1;
    tick();
    clear_inputs();

    // Reset while in DRAIN
    bus.src_req = 12'h002;
    tick();
    chk("seqB taken", 32'(bus.wr_exp), 32'h1);
    clear_inputs();
    bus.fetch_ready = 1'b1;
    tick();
    bus.fetch_ready = 1'b0;
    tick();
    chk("seqB in_drain flush", 32'(bus.flush), 32'hF);
    resetn = 1'b0;
    tick();
    chk_all_zero("seqB reset");
    chk("seqB reset exc_now", 32'(bus.exc_now), 32'h0);
    resetn = 1'b1;
    bus.src_req = 12'h004;
    #1;
    chk("seqB idle exc_now", 32'(bus.exc_now), 32'h1);
    tick();
    chk("seqB retake wr_exp", 32'(bus.wr_exp), 32'h1);
    chk("seqB retake code", 32'(bus.exp_code), 32'h03);
    clear_inputs();

    // Randomised sweep against the reference model
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    m_code = 5'd0;
    m_epc  = 32'd0;
    for (int it = 0; it < 200; it++) begin
      bus.src_req     = 12'($urandom) & 12'($urandom) & 12'($urandom);
      bus.src_refill  = 12'($urandom);
      bus.src_badv    = 12'($urandom);
      bus.int_enable  = ($urandom_range(0, 3) == 0);
      bus.int_pending = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      bus.eret        = ($urandom_range(0, 3) == 0);
      bus.bev         = 1'($urandom);
      bus.exl         = 1'($urandom);
      bus.iv          = 1'($urandom);
      bus.epc_in      = $urandom;
      bus.exc_epc     = $urandom;
      for (int i = 0; i < NS; i++) begin
        bus.src_code[5*i +: 5]    = 5'($urandom);
        bus.src_vaddr[32*i +: 32] = $urandom;
      end
      ref_winner(bus.src_req, bus.int_enable, bus.int_pending, bus.eret, kind, idx);
      base   = bus.bev ? BOOTB : NORMB;
      e_code = m_code;
      e_epc  = m_epc;
      e_bwe  = 1'b0;
      e_badv = 32'h0;
      e_pc   = 32'h0;
      if (kind == 1) begin
        e_code = 5'd0;
        e_epc  = bus.exc_epc;
        e_pc   = base + (bus.iv ? 32'h200 : 32'h180);
      end else if (kind == 2) begin
        e_code = bus.src_code[5*idx +: 5];
        e_epc  = bus.exc_epc;
        e_bwe  = bus.src_badv[idx];
        e_badv = e_bwe ? bus.src_vaddr[32*idx +: 32] : 32'h0;
        e_pc   = base + ((bus.src_refill[idx] && !bus.exl) ? 32'h0 : 32'h180);
      end else if (kind == 3) begin
        e_pc = bus.epc_in;
      end
      #1;
      chk($sformatf("rnd%0d exc_now", it), 32'(bus.exc_now), 32'(kind != 0));
      tick();
      if (kind == 0) begin
        chk($sformatf("rnd%0d none wr_exp", it), 32'(bus.wr_exp), 32'h0);
        chk($sformatf("rnd%0d none valid", it),  32'(bus.new_pc_valid), 32'h0);
        chk($sformatf("rnd%0d none flush", it),  32'(bus.flush), 32'h0);
        continue;
      end
      m_code = e_code;
      m_epc  = e_epc;
      chk($sformatf("rnd%0d wr_exp", it),      32'(bus.wr_exp), 32'(kind != 3));
      chk($sformatf("rnd%0d clear_exl", it),   32'(bus.clear_exl), 32'(kind == 3));
      chk($sformatf("rnd%0d exp_code", it),    32'(bus.exp_code), 32'(e_code));
      chk($sformatf("rnd%0d epc", it),         bus.epc, e_epc);
      chk($sformatf("rnd%0d badvaddr_we", it), 32'(bus.badvaddr_we), 32'(e_bwe));
      chk($sformatf("rnd%0d badvaddr", it),    bus.badvaddr, e_badv);
      chk($sformatf("rnd%0d new_pc", it),      bus.new_pc, e_pc);
      chk($sformatf("rnd%0d flush", it),       32'(bus.flush), 32'hF);
      held_pc = e_pc;
      nstall = $urandom_range(0, 3);
      for (int j = 0; j < nstall; j++) begin
        #1;
        chk($sformatf("rnd%0d stall exc_now", it), 32'(bus.exc_now), 32'h0);
        tick();
        chk($sformatf("rnd%0d stall wr_exp", it), 32'(bus.wr_exp | bus.clear_exl), 32'h0);
        chk($sformatf("rnd%0d stall valid", it),  32'(bus.new_pc_valid), 32'h1);
        chk($sformatf("rnd%0d stall pc", it),     bus.new_pc, held_pc);
      end
      done_now = 1'($urandom);
      bus.fetch_ready = 1'b1;
      bus.fetch_done  = done_now;
      tick();
      bus.fetch_ready = 1'b0;
      bus.fetch_done  = 1'b0;
      chk($sformatf("rnd%0d hs valid", it), 32'(bus.new_pc_valid), 32'h0);
      if (!done_now) begin
        nstall = $urandom_range(0, 3);
        for (int j = 0; j < nstall; j++) begin
          tick();
          chk($sformatf("rnd%0d drain flush", it), 32'(bus.flush), 32'hF);
        end
        bus.fetch_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
      end
      chk($sformatf("rnd%0d flush_drop", it), 32'(bus.flush), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
